halt_dump_unit: RTL and testbench

Hardware producer of the end-of-run report that the simulation bench reads. It sits beside the pipeline top and watches the ID-stage `ebreak_pulse`/`ecall_pulse`. On a halt it stops fetch and waits for older instructions to drain. It then walks the register file through a dedicated read port and streams a fixed-format record over a valid/ready interface: cause+PC, cycle count, then x0..x31. A bench or a UART bridge consumes the stream.

---
 rtl/halt_dump_unit.sv | 167 ++++++++++++++++
 tb/tb_halt_dump_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/halt_dump_unit.sv
// halt_dump_unit: on EBREAK/ECALL, halts fetch, drains the pipe and
// streams a cause/PC, cycle-count and register-file record.
module halt_dump_unit #(
    parameter int NREGS        = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ebreak_pulse,
    input  logic        ecall_pulse,
    input  logic [31:0] id_pc,
    output logic        fetch_halt,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [1:0]  dump_kind,
    output logic [4:0]  dump_idx,
    output logic [31:0] dump_data,
    output logic        done
);

    typedef enum logic [2:0] {
        S_RUN,
        S_DRAIN,
        S_HDR,
        S_CYC_LO,
        S_CYC_HI,
        S_REG,
        S_DONE
    } state_e;

    localparam int         CW       = $clog2(DRAIN_CYCLES + 1);
    localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

    state_e        state_q, state_d;
    logic [63:0]   cyc_q, cyc_d;
    logic [63:0]   halt_cyc_q, halt_cyc_d;
    logic [31:0]   halt_pc_q, halt_pc_d;
    logic [1:0]    cause_q, cause_d;
    logic [CW-1:0] drain_q, drain_d;
    logic [4:0]    idx_q, idx_d;
    logic [1:0]    kind_q, kind_d;
    logic [4:0]    didx_q, didx_d;
    logic [31:0]   data_q, data_d;
    logic          hs;

    // Status outputs decode straight from state so reset drops them at once
    always_comb begin
        fetch_halt = (state_q != S_RUN);
        dump_valid = (state_q == S_HDR) || (state_q == S_CYC_LO) ||
                     (state_q == S_CYC_HI) || (state_q == S_REG);
        done       = (state_q == S_DONE);
        rf_raddr   = (state_q == S_REG) ? idx_q + 5'd1 : 5'd0;
        hs         = dump_valid && dump_ready;
    end

    assign dump_kind = kind_q;
    assign dump_idx  = didx_q;
    assign dump_data = data_q;

    // Next-state and beat-register loading; each beat loads on entry
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        halt_cyc_d = halt_cyc_q;
        halt_pc_d  = halt_pc_q;
        cause_d    = cause_q;
        drain_d    = drain_q;
        idx_d      = idx_q;
        kind_d     = kind_q;
        didx_d     = didx_q;
        data_d     = data_q;
        unique case (state_q)
            S_RUN: begin
                cyc_d = cyc_q + 64'd1;
                if (ebreak_pulse || ecall_pulse) begin
                    halt_cyc_d = cyc_q + 64'd1;
                    halt_pc_d  = id_pc;
                    cause_d    = ebreak_pulse ? 2'd1 : 2'd2;
                    drain_d    = '0;
                    state_d    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_q == CW'(DRAIN_CYCLES)) begin
                    state_d = S_HDR;
                    kind_d  = 2'd0;
                    didx_d  = {3'b000, cause_q};
                    data_d  = halt_pc_q;
                end else begin
                    drain_d = drain_q + CW'(1);
                end
            end
            S_HDR: begin
                if (hs) begin
                    state_d = S_CYC_LO;
                    kind_d  = 2'd1;
                    didx_d  = 5'd0;
                    data_d  = halt_cyc_q[31:0];
                end
            end
            S_CYC_LO: begin
                if (hs) begin
                    state_d = S_CYC_HI;
                    kind_d  = 2'd2;
                    didx_d  = 5'd0;
                    data_d  = halt_cyc_q[63:32];
                end
            end
            S_CYC_HI: begin
                if (hs) begin
                    state_d = S_REG;
                    idx_d   = 5'd0;
                    kind_d  = 2'd3;
                    didx_d  = 5'd0;
                    data_d  = 32'd0;
                end
            end
            S_REG: begin
                if (hs) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d  = idx_q + 5'd1;
                        didx_d = idx_q + 5'd1;
                        data_d = rf_rdata;
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // State and record registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            cyc_q      <= '0;
            halt_cyc_q <= '0;
            halt_pc_q  <= '0;
            cause_q    <= '0;
            drain_q    <= '0;
            idx_q      <= '0;
            kind_q     <= '0;
            didx_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            halt_cyc_q <= halt_cyc_d;
            halt_pc_q  <= halt_pc_d;
            cause_q    <= cause_d;
            drain_q    <= drain_d;
            idx_q      <= idx_d;
            kind_q     <= kind_d;
            didx_q     <= didx_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_halt_dump_unit.sv
// tb_halt_dump_unit: table-driven halt scenarios with random stalls,
// checked against a record model built from the halt rules.
module tb_halt_dump_unit;

    localparam int NREGS  = 32;
    localparam int DRAIN  = 4;
    localparam int NBEATS = NREGS + 3;

    typedef struct {
        logic        eb;
        logic        ec;
        logic [31:0] pc;
        int          pre;
        int          stall;
        bit          inject;
        bit          wr5;
        bit          wrap;
        logic [4:0]  exp_cause;
    } vec_t;

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ebreak_pulse = 1'b0;
    logic        ecall_pulse = 1'b0;
    logic [31:0] id_pc = 32'd0;
    logic        fetch_halt;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [1:0]  dump_kind;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        done;

    logic [31:0] rf [32];
    beat_t       got [$];
    beat_t       exp_q [$];
    vec_t        tbl [6];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    assign rf_rdata = rf[rf_raddr];

    halt_dump_unit #(
        .NREGS(NREGS),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ebreak_pulse(ebreak_pulse),
        .ecall_pulse(ecall_pulse),
        .id_pc(id_pc),
        .fetch_halt(fetch_halt),
        .rf_raddr(rf_raddr),
        .rf_rdata(rf_rdata),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_kind(dump_kind),
        .dump_idx(dump_idx),
        .dump_data(dump_data),
        .done(done)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outs(input string name);
        chk(name, 64'({fetch_halt, dump_valid, done, dump_kind,
                       dump_idx, dump_data, rf_raddr}), 64'd0);
    endtask

    task automatic run_record(input vec_t v, input int id);
        logic [63:0] base;
        logic [63:0] hcyc;
        int          n;
        int          first_v;
        int          last_hs;
        bit          hold;
        bit          injected;
        beat_t       prev;
        logic [4:0]  prev_ra;

        got.delete();
        exp_q.delete();
        #2;
        rst_n = 1'b0;
        ebreak_pulse = 1'b0;
        ecall_pulse = 1'b0;
        dump_ready = 1'b0;
        #1;
        chk_reset_outs($sformatf("v%0d_reset_outs", id));
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = 64'd0;
        if (v.wrap) begin
            force dut.cyc_q = 64'hFFFF_FFFF_FFFF_FFFE;
            #1;
            release dut.cyc_q;
            base = 64'hFFFF_FFFF_FFFF_FFFE;
        end

        for (int k = 1; k <= v.pre; k++) begin
            if (k == v.pre) begin
                ebreak_pulse = v.eb;
                ecall_pulse = v.ec;
                id_pc = v.pc;
            end else begin
                id_pc = $urandom;
            end
            @(posedge clk);
            #1;
            ebreak_pulse = 1'b0;
            ecall_pulse = 1'b0;
            if (k == v.pre - 1)
                chk($sformatf("v%0d_run_no_halt", id),
                    64'({fetch_halt, dump_valid}), 64'd0);
        end
        hcyc = base + 64'(v.pre);
        chk($sformatf("v%0d_halt_after_pulse", id),
            64'({fetch_halt, dump_valid}), 64'b10);

        n = 0;
        first_v = -1;
        last_hs = -10;
        hold = 1'b0;
        injected = 1'b0;
        prev = '{2'd0, 5'd0, 32'd0};
        prev_ra = 5'd0;
        while (!done && n < 600) begin
            if (dump_valid && first_v < 0) first_v = n;
            if (hold)
                chk($sformatf("v%0d_hold_n%0d", id, n),
                    64'({dump_valid, dump_kind, dump_idx, dump_data, rf_raddr}),
                    64'({1'b1, prev.kind, prev.idx, prev.data, prev_ra}));
            if (v.stall == 0)
                dump_ready = 1'b1;
            else
                dump_ready = (int'($urandom_range(99)) >= v.stall);
            if (v.inject && n == 2) ecall_pulse = 1'b1;
            if (v.inject && !injected && dump_valid &&
                dump_kind == 2'd3 && dump_idx == 5'd9) begin
                ecall_pulse = 1'b1;
                ebreak_pulse = 1'b1;
                injected = 1'b1;
            end
            if (v.wr5 && n == 3) rf[5] = 32'h0000_1234;
            if (dump_valid && dump_ready) begin
                got.push_back('{dump_kind, dump_idx, dump_data});
                last_hs = n;
            end
            hold = dump_valid && !dump_ready;
            prev = '{dump_kind, dump_idx, dump_data};
            prev_ra = rf_raddr;
            @(posedge clk);
            #1;
            ebreak_pulse = 1'b0;
            ecall_pulse = 1'b0;
            n++;
        end

        chk($sformatf("v%0d_done_timeout", id), 64'(done), 64'd1);
        chk($sformatf("v%0d_first_valid_edge", id), 64'(first_v), 64'(DRAIN + 1));
        chk($sformatf("v%0d_done_latency", id), 64'(n), 64'(last_hs + 1));
        chk($sformatf("v%0d_done_flags", id),
            64'({fetch_halt, dump_valid}), 64'b10);
        chk($sformatf("v%0d_beat_count", id), 64'(got.size()), 64'(NBEATS));

        exp_q.push_back('{2'd0, v.exp_cause, v.pc});
        exp_q.push_back('{2'd1, 5'd0, hcyc[31:0]});
        exp_q.push_back('{2'd2, 5'd0, hcyc[63:32]});
        for (int i = 0; i < NREGS; i++)
            exp_q.push_back('{2'd3, 5'(i), (i == 0) ? 32'd0 : rf[i]});
        for (int i = 0; i < NBEATS; i++) begin
            if (i < got.size())
                chk($sformatf("v%0d_beat%0d", id, i),
                    64'({got[i].kind, got[i].idx, got[i].data}),
                    64'({exp_q[i].kind, exp_q[i].idx, exp_q[i].data}));
        end

        ebreak_pulse = 1'b1;
        @(posedge clk);
        #1;
        ebreak_pulse = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk($sformatf("v%0d_no_second_record", id),
            64'({done, dump_valid, fetch_halt}), 64'b101);
    endtask

    initial begin
        bit found;

        tbl[0] = '{1'b1, 1'b0, 32'h0000_0040, 10, 0, 1'b0, 1'b1, 1'b0, 5'd1};
        tbl[1] = '{1'b1, 1'b1, 32'h0000_0100, 7, 0, 1'b1, 1'b0, 1'b0, 5'd1};
        tbl[2] = '{1'b0, 1'b1, $urandom, int'($urandom_range(30, 1)), 60,
                   1'b0, 1'b0, 1'b0, 5'd2};
        tbl[3] = '{1'b1, 1'b0, $urandom, 3, 0, 1'b0, 1'b0, 1'b1, 5'd1};
        tbl[4] = '{1'b0, 1'b1, $urandom, 2, 75, 1'b1, 1'b1, 1'b0, 5'd2};
        tbl[5] = '{1'b1, 1'b0, $urandom, 1, 50, 1'b0, 1'b0, 1'b0, 5'd1};

        for (int t = 0; t < 6; t++) run_record(tbl[t], t);

        // Abort mid-dump at register 17, then a fresh record from reset
        #2;
        rst_n = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dump_ready = 1'b1;
        ebreak_pulse = 1'b1;
        id_pc = 32'h0000_0ABC;
        @(posedge clk);
        #1;
        ebreak_pulse = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (dump_valid && dump_kind == 2'd3 && dump_idx == 5'd17)
                found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("abort_reach_idx17", 64'(found), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("abort_outs_drop");
        run_record(tbl[0], 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
